// File: rtl/seg7_cap_pkg.sv
// seg7_cap_pkg
// Shared types and widths for the seven-segment capture block.
//   SEG_W       : width of one digit's segment bus (bit 7 = decimal point)
//   FRAME_CNT_W : width of the completed-frame counter
//   ERR_CNT_W   : width of the multi-select error counter
//   IDX_W       : width of a digit index (up to 8 digits)
//   cap_state_t : frame assembly FSM states
package seg7_cap_pkg;

  localparam int SEG_W       = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int ERR_CNT_W   = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_sel_decode.sv
// seg7_sel_decode
// Combinational digit-select decoder. Normalises select polarity so a set
// bit always means "selected", then classifies the pattern.
// Ports:
//   sel   in  NUM_DIGITS  raw digit-select lines
//   valid out 1           exactly one digit selected
//   none  out 1           no digit selected (blanking)
//   multi out 1           two or more digits selected
//   idx   out IDX_W       position of the selected digit when valid
module seg7_sel_decode
  import seg7_cap_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic [NUM_DIGITS-1:0] sel,
  output logic                  valid,
  output logic                  none,
  output logic                  multi,
  output logic [IDX_W-1:0]      idx
);

  logic [NUM_DIGITS-1:0] norm;
  logic [3:0]            hits;

  // Count selected digits; idx keeps the last one found, which is the only
  // one whenever valid is asserted.
  always_comb begin
    norm = (SEL_ACTIVE_LOW != 0) ? ~sel : sel;
    hits = '0;
    idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (norm[i]) begin
        hits = hits + 4'd1;
        idx  = IDX_W'(i);
      end
    end
    none  = (hits == 4'd0);
    valid = (hits == 4'd1);
    multi = (hits >= 4'd2);
  end

endmodule

// File: rtl/seg7_capture_v2.sv
// seg7_capture_v2
// Captures a multiplexed seven-segment display into a full, tear-free frame.
// A digit is accepted once its {select, segments} pair has been stable for
// STABLE_CYCLES samples; when every digit has been accepted the frame is
// committed to LEDOUT_all in one step.
// Ports:
//   sysclk     in  1              clock, rising edge
//   rst        in  1              synchronous active-high reset
//   LEDSEL     in  NUM_DIGITS     digit-select lines
//   LEDOUT     in  8              segment lines, bit 7 = decimal point
//   clr_upd    in  1              clears upd (a commit in the same cycle wins)
//   LEDOUT_all out 8*NUM_DIGITS   committed frame, digit i at [8i+7:8i]
//   upd        out 1              sticky "frame changed" flag
//   frame_cnt  out 16             completed frames, wraps
//   err_cnt    out 8              multi-select events, saturating
// Optional feature: define SEG7_CAP_ERRCNT_EN to build the error counter;
// otherwise err_cnt is constant 0.
module seg7_capture_v2
  import seg7_cap_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         LEDSEL,
  input  logic [SEG_W-1:0]              LEDOUT,
  input  logic                          clr_upd,
  output logic [SEG_W*NUM_DIGITS-1:0]   LEDOUT_all,
  output logic                          upd,
  output logic [FRAME_CNT_W-1:0]        frame_cnt,
  output logic [ERR_CNT_W-1:0]          err_cnt
);

  localparam int FRAME_W = SEG_W * NUM_DIGITS;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  // Reset the select copies to "nothing selected" so reset itself never
  // looks like a multi-select pattern.
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [NUM_DIGITS-1:0] sel_q, sel_prev;
  logic [SEG_W-1:0]      seg_q, seg_prev;
  logic                  dec_valid, dec_none, dec_multi;
  logic [IDX_W-1:0]      dec_idx;
  logic [7:0]            stab_cnt, stab_next;
  logic                  changed, capture;
  cap_state_t            state;
  logic [NUM_DIGITS-1:0] mask;
  logic [FRAME_W-1:0]    work;

  // Single input register stage plus a delayed copy used to detect changes.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sel_q    <= SEL_IDLE;
      seg_q    <= '0;
      sel_prev <= SEL_IDLE;
      seg_prev <= '0;
    end else begin
      sel_q    <= LEDSEL;
      seg_q    <= LEDOUT;
      sel_prev <= sel_q;
      seg_prev <= seg_q;
    end
  end

  seg7_sel_decode #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
  ) u_decode (
    .sel   (sel_q),
    .valid (dec_valid),
    .none  (dec_none),
    .multi (dec_multi),
    .idx   (dec_idx)
  );

  // A changed pair counts as the first sample of a new dwell. Capture fires
  // only on the step that reaches STABLE_C, so a long dwell captures once.
  always_comb begin
    changed   = (sel_q != sel_prev) || (seg_q != seg_prev);
    stab_next = stab_cnt;
    if (dec_none)
      stab_next = 8'd0;
    else if (changed)
      stab_next = 8'd1;
    else if (stab_cnt != STABLE_C)
      stab_next = stab_cnt + 8'd1;
    capture = dec_valid && (stab_next == STABLE_C) &&
              (changed || (stab_cnt != STABLE_C));
  end

  // Stability counter register.
  always_ff @(posedge sysclk) begin
    if (rst) stab_cnt <= 8'd0;
    else     stab_cnt <= stab_next;
  end

  // Frame assembly FSM with working buffer, mask and committed outputs.
  // The mask clear in COMMIT is overridden by a same-cycle capture, which
  // starts the next frame.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      work       <= '0;
      LEDOUT_all <= '0;
      frame_cnt  <= '0;
      upd        <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (capture || (mask != '0)) state <= FILL;
        FILL:    if (&mask) state <= COMMIT;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == COMMIT) begin
        mask       <= '0;
        LEDOUT_all <= work;
        frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && (dec_idx == IDX_W'(i))) begin
          mask[i]                <= 1'b1;
          work[i*SEG_W +: SEG_W] <= seg_q;
        end
      end

      if ((state == COMMIT) && (work != LEDOUT_all))
        upd <= 1'b1;
      else if (clr_upd)
        upd <= 1'b0;
    end
  end

`ifdef SEG7_CAP_ERRCNT_EN
  logic multi_prev;

  // Count entries into a multi-select pattern, saturating at all ones.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      multi_prev <= 1'b0;
      err_cnt    <= '0;
    end else begin
      multi_prev <= dec_multi;
      if (dec_multi && !multi_prev && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  // Multi-select only feeds the error counter, which is compiled out here.
  logic unused_multi;
  assign unused_multi = dec_multi;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_seg7_capture_v2.sv
// tb_seg7_capture_v2
// Self-checking bench for seg7_capture_v2 at default parameters
// (4 digits, 4 stable samples, active-low select). Expected frames come from
// a frame-level model: each digit's value is the one from its last dwell of
// at least four cycles, a frame completes when all four digits have one.
module tb_seg7_capture_v2;

  logic        sysclk;
  logic        rst;
  logic [3:0]  LEDSEL;
  logic [7:0]  LEDOUT;
  logic        clr_upd;
  logic [31:0] LEDOUT_all;
  logic        upd;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_all;
  logic [15:0] exp_frames;
  logic        exp_upd;

  typedef struct {
    logic [31:0] segs;
    int          dwell;
    logic        clr_first;
    logic [31:0] exp_all;
    logic [15:0] exp_frames;
    logic        exp_upd;
  } frame_vec_t;

  frame_vec_t vecs[6];

  seg7_capture_v2 dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .LEDSEL     (LEDSEL),
    .LEDOUT     (LEDOUT),
    .clr_upd    (clr_upd),
    .LEDOUT_all (LEDOUT_all),
    .upd        (upd),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Hold one digit selected with the given segments for n cycles.
  task automatic applyStimulus(input int digit, input logic [7:0] seg, input int n);
    logic [3:0] s;
    s = 4'hF;
    s[digit] = 1'b0;
    LEDSEL = s;
    LEDOUT = seg;
    repeat (n) @(negedge sysclk);
  endtask

  // Drive the blanking pattern (no digit selected) for n cycles.
  task automatic blank(input int n);
    LEDSEL = 4'hF;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic pulseClr();
    clr_upd = 1'b1;
    @(negedge sysclk);
    clr_upd = 1'b0;
  endtask

  // Scan all four digits in order, each followed by one blank cycle.
  task automatic driveFrame(input logic [31:0] segs, input int dwell);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, segs[i*8 +: 8], dwell);
      blank(1);
    end
    blank(6);
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, " LEDOUT_all"}, LEDOUT_all, exp_all);
    checkOutput({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    checkOutput({tag, " upd"}, 32'(upd), 32'(exp_upd));
  endtask

  initial begin
    int          perm[4];
    int          j, tmp;
    logic [31:0] nf;
    logic [7:0]  exp_err;

    vecs[0] = '{32'h44332211, 6, 1'b0, 32'h44332211, 16'd1, 1'b1};
    vecs[1] = '{32'h44332211, 6, 1'b1, 32'h44332211, 16'd2, 1'b0};
    vecs[2] = '{32'h55667788, 5, 1'b0, 32'h55667788, 16'd3, 1'b1};
    vecs[3] = '{32'h55667788, 4, 1'b1, 32'h55667788, 16'd4, 1'b0};
    vecs[4] = '{32'h01020304, 3, 1'b0, 32'h55667788, 16'd4, 1'b0};
    vecs[5] = '{32'h0A0B0C0D, 4, 1'b1, 32'h0A0B0C0D, 16'd5, 1'b1};

    rst = 1'b1;
    LEDSEL = 4'hF;
    LEDOUT = 8'h00;
    clr_upd = 1'b0;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);

    checkOutput("reset LEDOUT_all", LEDOUT_all, 32'h0);
    checkOutput("reset upd", 32'(upd), 32'h0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'h0);
    checkOutput("reset err_cnt", 32'(err_cnt), 32'h0);

    // Directed frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr_first) pulseClr();
      driveFrame(vecs[v].segs, vecs[v].dwell);
      exp_all    = vecs[v].exp_all;
      exp_frames = vecs[v].exp_frames;
      exp_upd    = vecs[v].exp_upd;
      checkFrame($sformatf("vec%0d", v));
    end

    // Recapture of digit 0 within one frame keeps the later value.
    applyStimulus(0, 8'h10, 6);
    blank(1);
    applyStimulus(0, 8'h99, 6);
    blank(1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(i, 8'hA0 + 8'(i), 6);
      blank(1);
    end
    blank(6);
    exp_all = 32'hA3A2A199; exp_frames = 16'd6; exp_upd = 1'b1;
    checkFrame("recapture");

    // Digit 2 held only 3 cycles: frame stays incomplete until it is redone.
    pulseClr();
    applyStimulus(0, 8'h01, 6); blank(1);
    applyStimulus(1, 8'h02, 6); blank(1);
    applyStimulus(2, 8'h03, 3); blank(1);
    applyStimulus(3, 8'h04, 6); blank(6);
    exp_upd = 1'b0;
    checkFrame("short digit");
    applyStimulus(2, 8'h03, 6); blank(6);
    exp_all = 32'h04030201; exp_frames = 16'd7; exp_upd = 1'b1;
    checkFrame("short digit completed");

    // Multi-select events: two entries into a two-digit pattern.
    LEDOUT = 8'h77;
    LEDSEL = 4'b0011; repeat (10) @(negedge sysclk);
    LEDSEL = 4'b1111; @(negedge sysclk);
    LEDSEL = 4'b0011; repeat (4) @(negedge sysclk);
    blank(4);
`ifdef SEG7_CAP_ERRCNT_EN
    exp_err = 8'd2;
`else
    exp_err = 8'd0;
`endif
    checkOutput("multi err_cnt", 32'(err_cnt), 32'(exp_err));
    checkOutput("multi LEDOUT_all", LEDOUT_all, exp_all);

    // clr_upd in the COMMIT cycle: the set must win.
    pulseClr();
    applyStimulus(0, 8'hEF, 6); blank(1);
    applyStimulus(1, 8'hBE, 6); blank(1);
    applyStimulus(2, 8'hAD, 6); blank(1);
    applyStimulus(3, 8'hDE, 4);
    LEDSEL = 4'hF;
    @(negedge sysclk);  // capture edge
    @(negedge sysclk);  // COMMIT entered
    clr_upd = 1'b1;
    @(negedge sysclk);  // commit edge
    clr_upd = 1'b0;
    exp_all = 32'hDEADBEEF; exp_frames = 16'd8; exp_upd = 1'b1;
    checkFrame("clr in commit");
    pulseClr();
    checkOutput("clr after commit", 32'(upd), 32'h0);
    exp_upd = 1'b0;
    blank(2);

    // Randomised frames: shuffled digit order, random dwell lengths, short
    // glitch dwells that must be ignored, occasional repeated frames.
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulseClr();
        exp_upd = 1'b0;
      end
      nf = ($urandom_range(0, 3) == 0) ? exp_all : $urandom();
      for (int i = 0; i < 4; i++) perm[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          applyStimulus(int'($urandom_range(0, 3)), 8'($urandom()),
                        int'($urandom_range(1, 3)));
          blank(1);
        end
        applyStimulus(perm[k], nf[perm[k]*8 +: 8], int'($urandom_range(4, 8)));
        blank(int'($urandom_range(1, 2)));
      end
      blank(6);
      if (nf != exp_all) exp_upd = 1'b1;
      exp_all    = nf;
      exp_frames = exp_frames + 16'd1;
      checkFrame($sformatf("rand%0d", f));
    end

    // Reset in the middle of a frame discards the partial frame.
    applyStimulus(0, 8'h10, 6); blank(1);
    applyStimulus(1, 8'h20, 6); blank(1);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    checkOutput("midreset LEDOUT_all", LEDOUT_all, 32'h0);
    driveFrame(32'hDDCCBBAA, 6);
    exp_all = 32'hDDCCBBAA; exp_frames = 16'd1; exp_upd = 1'b1;
    checkFrame("after reset");

    // Frame counter wraps from all ones to zero.
    force dut.frame_cnt = 16'hFFFF;
    @(negedge sysclk);
    release dut.frame_cnt;
    driveFrame(32'h12345678, 6);
    checkOutput("frame_cnt wrap", 32'(frame_cnt), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
